// File: rtl/fft_frame_ctrl_if.sv
// Stream and FFT-core handshake bundle for fft_frame_ctrl; the controller connects through the
// slave modport, the sample source / FFT core / bin sink side through master.
interface fft_frame_ctrl_if #(
  parameter int N_POINTS = 8,
  parameter int DATA_W   = 8,
  parameter int BIN_W    = DATA_W + $clog2(N_POINTS) + 1,
  parameter int OUT_W    = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  logic                          fft_start;
  logic [N_POINTS*DATA_W-1:0]    fft_frame;
  logic                          fft_done;
  logic [N_POINTS*BIN_W-1:0]     fft_re;
  logic [N_POINTS*BIN_W-1:0]     fft_im;
  logic                          out_valid;
  logic                          out_ready;
  logic [OUT_W-1:0]              out_data;
  logic [$clog2(N_POINTS)-1:0]   out_index;
  logic                          out_last;
  logic                          busy;

  modport master (
    output in_valid, in_data, fft_done, fft_re, fft_im, out_ready,
    input  in_ready, fft_start, fft_frame, out_valid, out_data, out_index, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, fft_done, fft_re, fft_im, out_ready,
    output in_ready, fft_start, fft_frame, out_valid, out_data, out_index, out_last, busy
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame loader and power-spectrum back end: gathers N_POINTS samples, hands them to an FFT core,
// then streams saturated (re^2+im^2)>>MAG_SHIFT per bin. Define PEAK_DETECT_EN for peak outputs.
module fft_frame_ctrl #(
  parameter int N_POINTS      = 8,
  parameter int DATA_W        = 8,
  parameter int BIN_W         = DATA_W + $clog2(N_POINTS) + 1,
  parameter int OUT_W         = 8,
  parameter int MAG_SHIFT     = 6,
  parameter int HALF_SPECTRUM = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  fft_frame_ctrl_if.slave  bus
`ifdef PEAK_DETECT_EN
  ,
  output logic                        peak_valid,
  output logic [$clog2(N_POINTS)-1:0] peak_index,
  output logic [OUT_W-1:0]            peak_mag
`endif
);

  localparam int IDX_W = $clog2(N_POINTS);
  localparam int SQ_W  = 2 * BIN_W;
  localparam int SUM_W = SQ_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    (HALF_SPECTRUM != 0) ? IDX_W'(N_POINTS / 2) : IDX_W'(N_POINTS - 1);
  localparam logic [SUM_W-1:0] SAT_LIMIT = {{(SUM_W - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {COLLECT, WAIT_FFT, STREAM} state_t;

  state_t                  state;
  logic [DATA_W-1:0]       samples [N_POINTS];
  logic signed [BIN_W-1:0] bin_re  [N_POINTS];
  logic signed [BIN_W-1:0] bin_im  [N_POINTS];
  logic [IDX_W-1:0]        wr_cnt;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        rd_next;
  logic signed [SQ_W-1:0]  re_ext, im_ext, re_sq, im_sq;
  logic [SUM_W-1:0]        mag_sum, mag_shifted;
  logic [OUT_W-1:0]        mag_sat;

  assign rd_next       = rd_idx + IDX_W'(1);
  assign bus.out_index = rd_idx;

  always_comb begin
    bus.fft_frame = '0;
    for (int k = 0; k < N_POINTS; k++) begin
      bus.fft_frame[k*DATA_W +: DATA_W] = samples[k];
    end
  end

  // Operands are sign-extended to the full square width so -2^(BIN_W-1) squares without overflow.
  always_comb begin
    re_ext       = SQ_W'(bin_re[rd_idx]);
    im_ext       = SQ_W'(bin_im[rd_idx]);
    re_sq        = re_ext * re_ext;
    im_sq        = im_ext * im_ext;
    mag_sum      = {1'b0, re_sq} + {1'b0, im_sq};
    mag_shifted  = mag_sum >> MAG_SHIFT;
    mag_sat      = (mag_shifted > SAT_LIMIT) ? '1 : mag_shifted[OUT_W-1:0];
    bus.out_data = bus.out_valid ? mag_sat : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= COLLECT;
      wr_cnt        <= '0;
      rd_idx        <= '0;
      bus.fft_start <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.busy      <= 1'b0;
      for (int k = 0; k < N_POINTS; k++) begin
        samples[k] <= '0;
        bin_re[k]  <= '0;
        bin_im[k]  <= '0;
      end
    end else begin
      bus.fft_start <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.in_valid && bus.in_ready) begin
            samples[wr_cnt] <= bus.in_data;
            wr_cnt          <= wr_cnt + IDX_W'(1);
            if (wr_cnt == IDX_W'(N_POINTS - 1)) begin
              wr_cnt        <= '0;
              bus.fft_start <= 1'b1;
              bus.in_ready  <= 1'b0;
              bus.busy      <= 1'b1;
              state         <= WAIT_FFT;
            end
          end
        end
        WAIT_FFT: begin
          if (bus.fft_done) begin
            for (int k = 0; k < N_POINTS; k++) begin
              bin_re[k] <= bus.fft_re[k*BIN_W +: BIN_W];
              bin_im[k] <= bus.fft_im[k*BIN_W +: BIN_W];
            end
            rd_idx        <= '0;
            bus.out_valid <= 1'b1;
            bus.out_last  <= 1'b0;
            state         <= STREAM;
          end
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx        <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.busy      <= 1'b0;
              bus.in_ready  <= 1'b1;
              state         <= COLLECT;
            end else begin
              rd_idx       <= rd_next;
              bus.out_last <= (rd_next == LAST_IDX);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

`ifdef PEAK_DETECT_EN
  logic             have_cand;
  logic [OUT_W-1:0] run_mag, best_mag;
  logic [IDX_W-1:0] run_idx, best_idx;
  logic             take;

  // Strict compare keeps the lowest index on ties; DC is skipped unless the frame is tiny.
  always_comb begin
    take     = ((rd_idx != '0) || (N_POINTS <= 4)) && (!have_cand || (bus.out_data > run_mag));
    best_mag = take ? bus.out_data : run_mag;
    best_idx = take ? rd_idx : run_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_valid <= 1'b0;
      peak_index <= '0;
      peak_mag   <= '0;
      have_cand  <= 1'b0;
      run_mag    <= '0;
      run_idx    <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (rd_idx == LAST_IDX) begin
          peak_valid <= 1'b1;
          peak_index <= best_idx;
          peak_mag   <= best_mag;
          have_cand  <= 1'b0;
          run_mag    <= '0;
          run_idx    <= '0;
        end else begin
          have_cand <= have_cand | take;
          run_mag   <= best_mag;
          run_idx   <= best_idx;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: a full-spectrum N=8 instance and a half-spectrum N=16 instance,
// each served by a stub FFT core that returns hand-computed bins three cycles after fft_start.
module tb_fft_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n8, rst_n16;

  fft_frame_ctrl_if #(.N_POINTS(8))  bus8  ();
  fft_frame_ctrl_if #(.N_POINTS(16)) bus16 ();

`ifdef PEAK_DETECT_EN
  logic       peakValid8, peakValid16;
  logic [2:0] peakIndex8;
  logic [3:0] peakIndex16;
  logic [7:0] peakMag8, peakMag16;
`endif

  fft_frame_ctrl #(.N_POINTS(8), .HALF_SPECTRUM(0)) dut8 (
    .clk(clk), .rst_n(rst_n8), .bus(bus8.slave)
`ifdef PEAK_DETECT_EN
    , .peak_valid(peakValid8), .peak_index(peakIndex8), .peak_mag(peakMag8)
`endif
  );

  fft_frame_ctrl #(.N_POINTS(16), .HALF_SPECTRUM(1)) dut16 (
    .clk(clk), .rst_n(rst_n16), .bus(bus16.slave)
`ifdef PEAK_DETECT_EN
    , .peak_valid(peakValid16), .peak_index(peakIndex16), .peak_mag(peakMag16)
`endif
  );

  int checks = 0;
  int errors = 0;
  int starts8 = 0;
  int starts16 = 0;
  int startsBefore;

  logic       useBig = 1'b0;
  logic       drvValid = 1'b0, drvReady = 1'b0, drvDone = 1'b0;
  logic [7:0] drvData = '0;

  logic signed [7:0]  smp    [16];
  logic signed [12:0] binRe  [16];
  logic signed [12:0] binIm  [16];
  int                 expMag [16];

  // Synthetic bins for the backpressure frame: extremes, rounding and the saturation boundary.
  int bpRe  [8] = '{-2048, 8,   0, 24, -64, 100, 127, 128};
  int bpIm  [8] = '{-2048, 0, -16, 32,   0, -20,   0,   0};
  int bpMag [8] = '{  255, 1,   4, 25,  64, 162, 252, 255};

  assign bus8.in_valid   = drvValid && !useBig;
  assign bus16.in_valid  = drvValid && useBig;
  assign bus8.in_data    = drvData;
  assign bus16.in_data   = drvData;
  assign bus8.out_ready  = drvReady && !useBig;
  assign bus16.out_ready = drvReady && useBig;
  assign bus8.fft_done   = drvDone && !useBig;
  assign bus16.fft_done  = drvDone && useBig;

  always_comb begin
    bus8.fft_re  = '0;
    bus8.fft_im  = '0;
    bus16.fft_re = '0;
    bus16.fft_im = '0;
    for (int k = 0; k < 8; k++) begin
      bus8.fft_re[k*12 +: 12] = binRe[k][11:0];
      bus8.fft_im[k*12 +: 12] = binIm[k][11:0];
    end
    for (int k = 0; k < 16; k++) begin
      bus16.fft_re[k*13 +: 13] = binRe[k];
      bus16.fft_im[k*13 +: 13] = binIm[k];
    end
  end

  logic         curValid, curLast, curInReady, curBusy, curStart;
  logic [7:0]   curData;
  logic [3:0]   curIndex;
  logic [127:0] curFrame;

  assign curValid   = useBig ? bus16.out_valid : bus8.out_valid;
  assign curLast    = useBig ? bus16.out_last  : bus8.out_last;
  assign curInReady = useBig ? bus16.in_ready  : bus8.in_ready;
  assign curBusy    = useBig ? bus16.busy      : bus8.busy;
  assign curStart   = useBig ? bus16.fft_start : bus8.fft_start;
  assign curData    = useBig ? bus16.out_data  : bus8.out_data;
  assign curIndex   = useBig ? bus16.out_index : {1'b0, bus8.out_index};
  assign curFrame   = useBig ? bus16.fft_frame : {64'b0, bus8.fft_frame};

  always @(posedge clk) begin
    if (bus8.fft_start)  starts8++;
    if (bus16.fft_start) starts16++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not reach its end (got timeout, expected completion)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearFrame();
    for (int k = 0; k < 16; k++) begin
      smp[k]    = '0;
      binRe[k]  = '0;
      binIm[k]  = '0;
      expMag[k] = 0;
    end
  endtask

  task automatic applyStimulus(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      int cyc;
      cyc      = 0;
      drvValid = 1'b1;
      drvData  = smp[k];
      while (!curInReady && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 50) checkOutput("in_ready_timeout", 0, 1);
      @(negedge clk);
    end
    drvValid = 1'b0;
  endtask

  task automatic serveFft(input int n);
    int cyc;
    cyc = 0;
    while (!curStart && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("fft_start_seen", curStart, 1);
    checkOutput("busy_in_wait", curBusy, 1);
    checkOutput("in_ready_in_wait", curInReady, 0);
    for (int k = 0; k < n; k++) begin
      checkOutput("frame_slot", curFrame[k*8 +: 8], $unsigned(smp[k]));
    end
    repeat (2) @(negedge clk);
    drvDone = 1'b1;
    @(negedge clk);
    drvDone = 1'b0;
  endtask

  task automatic drainBins(input int lastIdx, input bit stall);
    int cyc;
    cyc = 0;
    while (!curValid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("out_valid_seen", curValid, 1);
    for (int i = 0; i <= lastIdx; i++) begin
      if (stall && (i % 2 == 1)) begin
        drvReady = 1'b0;
        repeat (2) begin
          @(negedge clk);
          checkOutput("stall_index", curIndex, i);
          checkOutput("stall_data", curData, expMag[i]);
          checkOutput("stall_in_ready", curInReady, 0);
        end
      end
      drvReady = 1'b1;
      checkOutput("bin_index", curIndex, i);
      checkOutput("bin_data", curData, expMag[i]);
      checkOutput("bin_last", curLast, (i == lastIdx));
      @(negedge clk);
    end
    drvReady = 1'b0;
    checkOutput("after_valid", curValid, 0);
    checkOutput("after_in_ready", curInReady, 1);
    checkOutput("after_busy", curBusy, 0);
  endtask

  task automatic runFrame8(input bit stall);
    startsBefore = starts8;
    applyStimulus(0, 8);
    serveFft(8);
    drainBins(7, stall);
    @(negedge clk);
    checkOutput("start_count", starts8 - startsBefore, 1);
  endtask

  initial begin
    clearFrame();
    rst_n8  = 1'b0;
    rst_n16 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n8  = 1'b1;
    rst_n16 = 1'b1;
    @(negedge clk);

    checkOutput("reset_in_ready", bus8.in_ready, 1);
    checkOutput("reset_fft_start", bus8.fft_start, 0);
    checkOutput("reset_out_valid", bus8.out_valid, 0);
    checkOutput("reset_out_last", bus8.out_last, 0);
    checkOutput("reset_out_index", bus8.out_index, 0);
    checkOutput("reset_out_data", bus8.out_data, 0);
    checkOutput("reset_busy", bus8.busy, 0);
    checkOutput("reset_frame", bus8.fft_frame, 0);
    checkOutput("reset_in_ready16", bus16.in_ready, 1);

    // A stray fft_done while collecting must not start streaming.
    binRe[0] = 13'sd100;
    drvDone  = 1'b1;
    @(negedge clk);
    drvDone = 1'b0;
    @(negedge clk);
    checkOutput("stray_done_valid", bus8.out_valid, 0);
    checkOutput("stray_done_busy", bus8.busy, 0);
    checkOutput("stray_done_in_ready", bus8.in_ready, 1);

    clearFrame();
    for (int k = 0; k < 8; k++) smp[k] = 8'sd10;
    binRe[0]  = 13'sd80;
    expMag[0] = 100;
    runFrame8(1'b0);

    clearFrame();
    smp[0] = 8'sd16;
    for (int k = 0; k < 8; k++) begin
      binRe[k]  = 13'sd16;
      expMag[k] = 4;
    end
    runFrame8(1'b0);

    clearFrame();
    for (int k = 0; k < 8; k++) smp[k] = 8'sd127;
    binRe[0]  = 13'sd1016;
    expMag[0] = 255;
    runFrame8(1'b0);

    clearFrame();
    for (int k = 0; k < 8; k++) smp[k] = -8'sd128;
    binRe[0]  = -13'sd1024;
    expMag[0] = 255;
    runFrame8(1'b0);

    clearFrame();
    for (int k = 0; k < 8; k++) begin
      smp[k]    = 8'(k * 7 - 20);
      binRe[k]  = 13'(bpRe[k]);
      binIm[k]  = 13'(bpIm[k]);
      expMag[k] = bpMag[k];
    end
    runFrame8(1'b1);

`ifdef PEAK_DETECT_EN
    clearFrame();
    smp[0] = 8'sd64; smp[2] = -8'sd64; smp[4] = 8'sd64; smp[6] = -8'sd64;
    binRe[2]  = 13'sd256;
    binRe[6]  = 13'sd256;
    expMag[2] = 255;
    expMag[6] = 255;
    applyStimulus(0, 8);
    serveFft(8);
    drainBins(7, 1'b0);
    checkOutput("peak_valid_pulse", peakValid8, 1);
    checkOutput("peak_index", peakIndex8, 2);
    checkOutput("peak_mag", peakMag8, 255);
    @(negedge clk);
    checkOutput("peak_valid_clear", peakValid8, 0);
    checkOutput("peak_mag_hold", peakMag8, 255);
`endif

    useBig = 1'b1;
    clearFrame();
    smp[0] = 8'sd16;
    for (int k = 0; k < 16; k++) begin
      binRe[k]  = 13'sd16;
      expMag[k] = 4;
    end
    startsBefore = starts16;
    applyStimulus(0, 16);
    serveFft(16);
    drainBins(8, 1'b0);
    @(negedge clk);
    checkOutput("half_start_count", starts16 - startsBefore, 1);

    // Abort a partial frame: 5 + 15 samples must not be enough to trigger fft_start.
    for (int k = 0; k < 16; k++) smp[k] = 8'(k + 1);
    startsBefore = starts16;
    applyStimulus(0, 5);
    rst_n16 = 1'b0;
    @(negedge clk);
    rst_n16 = 1'b1;
    @(negedge clk);
    checkOutput("midreset_in_ready", bus16.in_ready, 1);
    checkOutput("midreset_busy", bus16.busy, 0);
    applyStimulus(0, 15);
    repeat (3) @(negedge clk);
    checkOutput("midreset_no_early_start", starts16 - startsBefore, 0);
    applyStimulus(15, 1);
    serveFft(16);
    drainBins(8, 1'b0);
    @(negedge clk);
    checkOutput("midreset_start_count", starts16 - startsBefore, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
